// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch handshake, opcode decode into immediate-type
// enables, and sequencing of PC update, data-memory access and register write-back.
module rv32i_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  output logic        I_type_en,
  output logic        L_type_en,
  output logic        S_type_en,
  output logic        B_type_en,
  output logic        J_type_en,
  output logic        U_type_en,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        instr_retired,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_U     = 4'd0,
    CLS_J     = 4'd1,
    CLS_JALR  = 4'd2,
    CLS_B     = 4'd3,
    CLS_L     = 4'd4,
    CLS_S     = 4'd5,
    CLS_I     = 4'd6,
    CLS_OP    = 4'd7,
    CLS_FENCE = 4'd8,
    CLS_ILL   = 4'd9
  } cls_t;

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111: classify = CLS_U;
      7'b1101111:             classify = CLS_J;
      7'b1100111:             classify = CLS_JALR;
      7'b1100011:             classify = CLS_B;
      7'b0000011:             classify = CLS_L;
      7'b0100011:             classify = CLS_S;
      7'b0010011:             classify = CLS_I;
      7'b0110011:             classify = CLS_OP;
      7'b0001111:             classify = CLS_FENCE;
      default:                classify = CLS_ILL;
    endcase
  endfunction

  state_t     state_r;
  logic [6:0] opcode_r;
  logic [4:0] rd_r;
  // Clears on reset so no request is raised until the first clock after release.
  logic       live_r;
  cls_t       cls_s;
  logic       unused_s;

  assign cls_s    = classify(opcode_r);
  assign ir_we    = imem_req & imem_ready;
  assign unused_s = ^instr[31:12];

  // State register and latched opcode/rd fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_FETCH;
      opcode_r <= 7'd0;
      rd_r     <= 5'd0;
      live_r   <= 1'b0;
    end else begin
      live_r <= 1'b1;
      case (state_r)
        ST_FETCH: begin
          if (ir_we) begin
            opcode_r <= instr[6:0];
            rd_r     <= instr[11:7];
            state_r  <= ST_DECODE;
          end else begin
            state_r  <= ST_FETCH;
          end
        end
        ST_DECODE: state_r <= (cls_s == CLS_ILL) ? ST_HALT : ST_EXEC;
        ST_EXEC: begin
          if (cls_s == CLS_L || cls_s == CLS_S) begin
            state_r <= ST_MEM;
          end else if (cls_s == CLS_B) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            state_r <= (cls_s == CLS_S) ? ST_FETCH : ST_WB;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB:   state_r <= ST_FETCH;
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  // Immediate-type enables, held from DECODE through WB.
  always_comb begin
    I_type_en = 1'b0;
    L_type_en = 1'b0;
    S_type_en = 1'b0;
    B_type_en = 1'b0;
    J_type_en = 1'b0;
    U_type_en = 1'b0;
    if (state_r == ST_DECODE || state_r == ST_EXEC || state_r == ST_MEM || state_r == ST_WB) begin
      case (cls_s)
        CLS_I, CLS_JALR: I_type_en = 1'b1;
        CLS_L:           L_type_en = 1'b1;
        CLS_S:           S_type_en = 1'b1;
        CLS_B:           B_type_en = 1'b1;
        CLS_J:           J_type_en = 1'b1;
        CLS_U:           U_type_en = 1'b1;
        default:         I_type_en = 1'b0;
      endcase
    end else begin
      I_type_en = 1'b0;
    end
  end

  // Strobes and selects for the current state; branch and store retire without a WB cycle.
  always_comb begin
    imem_req      = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 2'b00;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = 2'b00;
    instr_retired = 1'b0;
    halted        = 1'b0;
    case (state_r)
      ST_FETCH: imem_req = live_r;
      ST_EXEC: begin
        if (cls_s == CLS_B) begin
          pc_we         = 1'b1;
          pc_sel        = {1'b0, branch_taken};
          instr_retired = 1'b1;
        end else begin
          pc_we         = 1'b0;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_s == CLS_S);
        if (dmem_ready && cls_s == CLS_S) begin
          pc_we         = 1'b1;
          instr_retired = 1'b1;
        end else begin
          pc_we         = 1'b0;
        end
      end
      ST_WB: begin
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        reg_we        = (cls_s != CLS_FENCE) && (rd_r != 5'd0);
        case (cls_s)
          CLS_J: begin
            pc_sel = 2'b01;
            wb_sel = 2'b10;
          end
          CLS_JALR: begin
            pc_sel = 2'b10;
            wb_sel = 2'b10;
          end
          CLS_L:   wb_sel = 2'b01;
          default: wb_sel = 2'b00;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule
